// File: rtl/pad_cfg_ctrl.sv
// Pad configuration controller: shadow/active pad config banks behind a valid/ready
// register port, plus input synchronisers for raw pad data.
module pad_cfg_ctrl #(
    parameter int NUM_BIDIR_PADS = 37,
    parameter int NUM_INPUT_PADS = 16,
    parameter int SYNC_STAGES    = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cfg_valid,
    output logic                      cfg_ready,
    input  logic                      cfg_we,
    input  logic [6:0]                cfg_addr,
    input  logic [7:0]                cfg_wdata,
    output logic                      cfg_ack,
    output logic                      cfg_err,
    output logic [7:0]                cfg_rdata,
    input  logic                      commit,
    output logic                      busy,
    input  logic [NUM_BIDIR_PADS-1:0] bidir_in_raw,
    output logic [NUM_BIDIR_PADS-1:0] bidir_in_sync,
    input  logic [NUM_INPUT_PADS-1:0] input_in_raw,
    output logic [NUM_INPUT_PADS-1:0] input_in_sync,
    output logic [NUM_BIDIR_PADS-1:0] bidir_oe,
    output logic [NUM_BIDIR_PADS-1:0] bidir_cs,
    output logic [NUM_BIDIR_PADS-1:0] bidir_sl,
    output logic [NUM_BIDIR_PADS-1:0] bidir_ie,
    output logic [NUM_BIDIR_PADS-1:0] bidir_pu,
    output logic [NUM_BIDIR_PADS-1:0] bidir_pd,
    output logic [NUM_INPUT_PADS-1:0] input_pu,
    output logic [NUM_INPUT_PADS-1:0] input_pd
);

    localparam int NB = NUM_BIDIR_PADS;
    localparam int NI = NUM_INPUT_PADS;
    localparam logic [6:0] NB_LIM = 7'(NB);
    localparam logic [6:0] NI_LIM = 7'(NI);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RESP,
        ST_COMMIT
    } state_e;

    state_e state_q, state_d;

    // Bidir word layout matches cfg_wdata[5:0]: [0]oe [1]ie [2]pu [3]pd [4]cs [5]sl
    logic [NB-1:0][5:0] shadow_b_q, shadow_b_d;
    logic [NB-1:0][5:0] active_b_q, active_b_d;
    // Input-pad word: [0]pu [1]pd
    logic [NI-1:0][1:0] shadow_i_q, shadow_i_d;
    logic [NI-1:0][1:0] active_i_q, active_i_d;

    logic       resp_err_q, resp_err_d;
    logic [7:0] resp_rdata_q, resp_rdata_d;

    logic [NB-1:0] bidir_sync_q [SYNC_STAGES];
    logic [NB-1:0] bidir_sync_d [SYNC_STAGES];
    logic [NI-1:0] input_sync_q [SYNC_STAGES];
    logic [NI-1:0] input_sync_d [SYNC_STAGES];

    logic [5:0] pad_idx;
    logic       bidir_hit;
    logic       input_hit;
    logic [7:0] rd_word;
    logic       unused_wdata;

    assign pad_idx      = cfg_addr[5:0];
    assign bidir_hit    = !cfg_addr[6] && ({1'b0, pad_idx} < NB_LIM);
    assign input_hit    = cfg_addr[6] && ({1'b0, pad_idx} < NI_LIM);
    assign unused_wdata = ^cfg_wdata[7:6];

    always_comb begin
        rd_word = 8'h00;
        for (int i = 0; i < NB; i++) begin
            if (bidir_hit && pad_idx == 6'(i)) rd_word = {2'b00, shadow_b_q[i]};
        end
        for (int i = 0; i < NI; i++) begin
            if (input_hit && pad_idx == 6'(i)) rd_word = {4'b0000, shadow_i_q[i], 2'b00};
        end
    end

    // Commit has priority over a request arriving in the same IDLE cycle.
    always_comb begin
        state_d      = state_q;
        shadow_b_d   = shadow_b_q;
        shadow_i_d   = shadow_i_q;
        active_b_d   = active_b_q;
        active_i_d   = active_i_q;
        resp_err_d   = resp_err_q;
        resp_rdata_d = resp_rdata_q;
        cfg_ready    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cfg_ready = ~commit;
                if (commit) begin
                    state_d = ST_COMMIT;
                end else if (cfg_valid) begin
                    state_d      = ST_RESP;
                    resp_err_d   = ~(bidir_hit | input_hit);
                    resp_rdata_d = cfg_we ? 8'h00 : rd_word;
                    if (cfg_we) begin
                        for (int i = 0; i < NB; i++) begin
                            if (bidir_hit && pad_idx == 6'(i)) shadow_b_d[i] = cfg_wdata[5:0];
                        end
                        for (int i = 0; i < NI; i++) begin
                            if (input_hit && pad_idx == 6'(i)) shadow_i_d[i] = cfg_wdata[3:2];
                        end
                    end
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            ST_COMMIT: begin
                state_d = ST_IDLE;
                // A pu+pd conflict resolves to pull-up only on the pads.
                for (int i = 0; i < NB; i++) begin
                    active_b_d[i] = shadow_b_q[i];
                    if (shadow_b_q[i][2]) active_b_d[i][3] = 1'b0;
                end
                for (int i = 0; i < NI; i++) begin
                    active_i_d[i] = shadow_i_q[i];
                    if (shadow_i_q[i][0]) active_i_d[i][1] = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        bidir_sync_d[0] = bidir_in_raw;
        input_sync_d[0] = input_in_raw;
        for (int s = 1; s < SYNC_STAGES; s++) begin
            bidir_sync_d[s] = bidir_sync_q[s-1];
            input_sync_d[s] = input_sync_q[s-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            shadow_b_q   <= {NB{6'h02}};
            active_b_q   <= {NB{6'h02}};
            shadow_i_q   <= '0;
            active_i_q   <= '0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= 8'h00;
            for (int s = 0; s < SYNC_STAGES; s++) begin
                bidir_sync_q[s] <= '0;
                input_sync_q[s] <= '0;
            end
        end else begin
            state_q      <= state_d;
            shadow_b_q   <= shadow_b_d;
            active_b_q   <= active_b_d;
            shadow_i_q   <= shadow_i_d;
            active_i_q   <= active_i_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
            for (int s = 0; s < SYNC_STAGES; s++) begin
                bidir_sync_q[s] <= bidir_sync_d[s];
                input_sync_q[s] <= input_sync_d[s];
            end
        end
    end

    assign cfg_ack       = (state_q == ST_RESP);
    assign cfg_err       = cfg_ack & resp_err_q;
    assign cfg_rdata     = cfg_ack ? resp_rdata_q : 8'h00;
    assign busy          = (state_q != ST_IDLE);
    assign bidir_in_sync = bidir_sync_q[SYNC_STAGES-1];
    assign input_in_sync = input_sync_q[SYNC_STAGES-1];

    always_comb begin
        for (int i = 0; i < NB; i++) begin
            bidir_oe[i] = active_b_q[i][0];
            bidir_ie[i] = active_b_q[i][1];
            bidir_pu[i] = active_b_q[i][2];
            bidir_pd[i] = active_b_q[i][3];
            bidir_cs[i] = active_b_q[i][4];
            bidir_sl[i] = active_b_q[i][5];
        end
        for (int i = 0; i < NI; i++) begin
            input_pu[i] = active_i_q[i][0];
            input_pd[i] = active_i_q[i][1];
        end
    end

endmodule
